// File: rtl/copy_csr_slave_if.sv
// Bundle for copy_csr_slave. It carries the Avalon-MM slave bus on the CPU side
// and the parameter/enable/copying handshake on the copy-master side.
interface copy_csr_slave_if;
  logic [3:0]  slave_address;
  logic        slave_read;
  logic        slave_write;
  logic [31:0] slave_writedata;
  logic [31:0] slave_readdata;
  logic        slave_waitrequest;
  logic [31:0] dest_addr;
  logic [31:0] src_addr;
  logic [31:0] num_words;
  logic        enable;
  logic        copying;

  // Register-file view: it receives the CPU bus and the copying flag
  modport slave (
    input  slave_address, slave_read, slave_write, slave_writedata, copying,
    output slave_readdata, slave_waitrequest, dest_addr, src_addr, num_words, enable
  );

  // CPU and copy-master view (the testbench side)
  modport master (
    output slave_address, slave_read, slave_write, slave_writedata, copying,
    input  slave_readdata, slave_waitrequest, dest_addr, src_addr, num_words, enable
  );
endinterface

// File: rtl/copy_csr_slave.sv
// CSR slave in front of the SDRAM word-copy master. The CPU programs DEST, SRC
// and NUM, then writes CTRL to start a copy. Reads of CTRL stall until the copy
// finishes. The block also reports status, error flags, the duration of the
// last copy and the number of completed copies.
module copy_csr_slave #(
  parameter int unsigned START_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  copy_csr_slave_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, LAUNCH, BUSY} state_t;

  localparam logic [31:0] TMO_LAST = 32'(START_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [31:0] dest_q, dest_d;
  logic [31:0] src_q, src_d;
  logic [31:0] num_q, num_d;
  logic [31:0] cycles_q, cycles_d;
  logic [31:0] count_q, count_d;
  logic [31:0] work_q, work_d;
  logic        zero_err_q, zero_err_d;
  logic        misalign_err_q, misalign_err_d;
  logic        timeout_err_q, timeout_err_d;

  logic        stall;
  logic        wr_acc;
  logic        start_wr;
  logic        start_ok;
  logic        launch_timeout;
  logic        copy_done;
  logic [31:0] work_inc;
  logic [31:0] status;

  // Decode bus accesses and FSM events shared by the processes below
  always_comb begin
    stall = 1'b0;
    if (state_q != IDLE) begin
      if ((bus.slave_read || bus.slave_write) && bus.slave_address == 4'd0)
        stall = 1'b1;
      else if (bus.slave_write && bus.slave_address >= 4'd1 && bus.slave_address <= 4'd3)
        stall = 1'b1;
    end
    wr_acc   = bus.slave_write && !stall;
    start_wr = (state_q == IDLE) && bus.slave_write && bus.slave_address == 4'd0;
    start_ok = start_wr && (num_q != '0) && (dest_q[1:0] == 2'b00) && (src_q[1:0] == 2'b00);
    // The working counter holds the number of LAUNCH cycles already spent, so it also serves as the start timeout counter
    launch_timeout = (state_q == LAUNCH) && !bus.copying && (work_q == TMO_LAST);
    copy_done      = (state_q == BUSY) && !bus.copying;
    work_inc       = (work_q == '1) ? work_q : work_q + 32'd1;
    status         = {28'd0, timeout_err_q, misalign_err_q, zero_err_q, (state_q != IDLE)};
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic. copying seen while idle is ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = LAUNCH;
      LAUNCH: begin
        if (bus.copying)         state_d = BUSY;
        else if (launch_timeout) state_d = IDLE;
      end
      BUSY:    if (!bus.copying) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM and register-file outputs to the bus and the copy master
  always_comb begin
    bus.enable            = (state_q == LAUNCH);
    bus.slave_waitrequest = stall;
    bus.dest_addr         = dest_q;
    bus.src_addr          = src_q;
    bus.num_words         = num_q;
    bus.slave_readdata    = '0;
    if (bus.slave_read && !stall) begin
      case (bus.slave_address)
        4'd1:    bus.slave_readdata = dest_q;
        4'd2:    bus.slave_readdata = src_q;
        4'd3:    bus.slave_readdata = num_q;
        4'd4:    bus.slave_readdata = status;
        4'd5:    bus.slave_readdata = cycles_q;
        4'd6:    bus.slave_readdata = count_q;
        default: bus.slave_readdata = '0;
      endcase
    end
  end

  // Next values for the register file, error flags and copy counters
  always_comb begin
    dest_d         = dest_q;
    src_d          = src_q;
    num_d          = num_q;
    cycles_d       = cycles_q;
    count_d        = count_q;
    work_d         = work_q;
    zero_err_d     = zero_err_q;
    misalign_err_d = misalign_err_q;
    timeout_err_d  = timeout_err_q;

    if (wr_acc) begin
      case (bus.slave_address)
        4'd1:    dest_d = bus.slave_writedata;
        4'd2:    src_d  = bus.slave_writedata;
        4'd3:    num_d  = bus.slave_writedata;
        default: ;
      endcase
    end

    if (start_wr) begin
      zero_err_d     = 1'b0;
      misalign_err_d = 1'b0;
      timeout_err_d  = 1'b0;
      if (num_q == '0)
        zero_err_d = 1'b1;
      else if (dest_q[1:0] != 2'b00 || src_q[1:0] != 2'b00)
        misalign_err_d = 1'b1;
      else
        work_d = '0;
    end

    if (state_q != IDLE) work_d = work_inc;

    if (launch_timeout) timeout_err_d = 1'b1;

    if (copy_done) begin
      count_d  = count_q + 32'd1;
      cycles_d = work_inc;
    end
  end

  // Register-file and counter state
  always_ff @(posedge clk) begin
    if (rst) begin
      dest_q         <= '0;
      src_q          <= '0;
      num_q          <= '0;
      cycles_q       <= '0;
      count_q        <= '0;
      work_q         <= '0;
      zero_err_q     <= 1'b0;
      misalign_err_q <= 1'b0;
      timeout_err_q  <= 1'b0;
    end else begin
      dest_q         <= dest_d;
      src_q          <= src_d;
      num_q          <= num_d;
      cycles_q       <= cycles_d;
      count_q        <= count_d;
      work_q         <= work_d;
      zero_err_q     <= zero_err_d;
      misalign_err_q <= misalign_err_d;
      timeout_err_q  <= timeout_err_d;
    end
  end

endmodule

// File: tb/tb_copy_csr_slave.sv
// Directed testbench for copy_csr_slave. A vector table checks register
// write/readback while idle. Hand-written sequences cover copy launch, stalls,
// errors, timeout and reset in the middle of a copy.
module tb_copy_csr_slave;

  logic clk = 1'b0;
  logic rst;

  copy_csr_slave_if bus ();

  copy_csr_slave #(.START_TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Free-running 100 MHz clock
  always #5 clk = ~clk;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  int unsigned en_total = 0;

  // Count the cycles in which enable is high, sampled on the falling edge
  always @(negedge clk) if (bus.enable === 1'b1) en_total <= en_total + 1;

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic bound_fail(input string name);
    n_total++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d, output int unsigned waited);
    @(negedge clk);
    bus.slave_address   = a;
    bus.slave_writedata = d;
    bus.slave_write     = 1'b1;
    #1;
    waited = 0;
    while (bus.slave_waitrequest === 1'b1 && waited < 200) begin
      @(negedge clk); #1; waited++;
    end
    if (bus.slave_waitrequest !== 1'b0) bound_fail("write_stall");
    @(posedge clk); #1;
    bus.slave_write = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d, output int unsigned waited);
    @(negedge clk);
    bus.slave_address = a;
    bus.slave_read    = 1'b1;
    #1;
    waited = 0;
    while (bus.slave_waitrequest === 1'b1 && waited < 200) begin
      @(negedge clk); #1; waited++;
    end
    if (bus.slave_waitrequest !== 1'b0) bound_fail("read_stall");
    d = bus.slave_readdata;
    @(posedge clk); #1;
    bus.slave_read = 1'b0;
  endtask

  // Copy-master model: after enable is first seen, wait dly cycles, then hold copying high for len cycles
  task automatic copy_model(input int unsigned dly, input int unsigned len);
    int unsigned n = 0;
    @(negedge clk);
    while (bus.enable !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    if (bus.enable !== 1'b1) bound_fail("copy_model_enable");
    else begin
      repeat (dly) @(negedge clk);
      bus.copying = 1'b1;
      repeat (len) @(negedge clk);
      bus.copying = 1'b0;
    end
  endtask

  task automatic read_check(input string name, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    int unsigned w;
    bus_read(a, rd, w);
    check(name, rd, exp);
  endtask

  vec_t vecs[10];

  initial begin
    logic [31:0] rd;
    int unsigned w, w2, base, n;
    logic hold_ok;

    vecs[0] = '{4'd1,  32'hDEADBEEF, 32'hDEADBEEF};
    vecs[1] = '{4'd2,  32'h12345678, 32'h12345678};
    vecs[2] = '{4'd3,  32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[3] = '{4'd1,  32'h00000000, 32'h00000000};
    vecs[4] = '{4'd4,  32'hFFFFFFFF, 32'h00000000};
    vecs[5] = '{4'd5,  32'hFFFFFFFF, 32'h00000000};
    vecs[6] = '{4'd6,  32'hFFFFFFFF, 32'h00000000};
    vecs[7] = '{4'd7,  32'hA5A5A5A5, 32'h00000000};
    vecs[8] = '{4'd15, 32'hFFFFFFFF, 32'h00000000};
    vecs[9] = '{4'd9,  32'h00000001, 32'h00000000};

    bus.slave_address   = '0;
    bus.slave_read      = 1'b0;
    bus.slave_write     = 1'b0;
    bus.slave_writedata = '0;
    bus.copying         = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;

    // Reset state
    check("rst_enable", {31'd0, bus.enable}, 32'd0);
    check("rst_waitrequest", {31'd0, bus.slave_waitrequest}, 32'd0);
    check("rst_readdata", bus.slave_readdata, 32'd0);
    check("rst_dest", bus.dest_addr, 32'd0);
    check("rst_num", bus.num_words, 32'd0);

    // Write/readback table while idle
    for (int i = 0; i < 10; i++) begin
      bus_write(vecs[i].addr, vecs[i].wdata, w);
      bus_read(vecs[i].addr, rd, w2);
      check($sformatf("vec%0d_rd", i), rd, vecs[i].exp);
      check($sformatf("vec%0d_nostall", i), w + w2, 32'd0);
    end
    check("tbl_src_out", bus.src_addr, 32'h12345678);
    check("tbl_num_out", bus.num_words, 32'hFFFFFFFF);

    // Zero-length start
    bus_write(3, 32'd0, w);
    base = en_total;
    bus_write(0, 32'd1, w);
    repeat (5) @(negedge clk);
    #1;
    check("zero_no_enable", en_total - base, 32'd0);
    read_check("zero_status", 4, 32'h2);
    read_check("zero_count", 6, 32'd0);

    // Normal copy
    bus_write(1, 32'h1000, w);
    bus_write(2, 32'h2000, w);
    bus_write(3, 32'd4, w);
    check("norm_dest_out", bus.dest_addr, 32'h1000);
    check("norm_src_out", bus.src_addr, 32'h2000);
    check("norm_num_out", bus.num_words, 32'd4);
    base = en_total;
    fork
      copy_model(2, 10);
      begin
        bus_write(0, 32'd1, w);
        bus_read(0, rd, w2);
      end
    join
    @(negedge clk); #1;
    check("norm_ctrl_rd", rd, 32'd0);
    check("norm_ctrl_stalled", {31'd0, (w2 > 0)}, 32'd1);
    check("norm_enable_cycles", en_total - base, 32'd3);
    read_check("norm_count", 6, 32'd1);
    read_check("norm_cycles", 5, 32'd13);
    read_check("norm_status", 4, 32'd0);

    // Misaligned source
    bus_write(2, 32'h2002, w);
    bus_write(3, 32'd1, w);
    base = en_total;
    bus_write(0, 32'd1, w);
    repeat (5) @(negedge clk);
    #1;
    check("mis_no_enable", en_total - base, 32'd0);
    read_check("mis_status", 4, 32'h4);

    // Valid restart, then stall rules during BUSY
    bus_write(2, 32'h2000, w);
    bus_write(3, 32'd4, w);
    fork
      copy_model(2, 20);
      begin
        bus_write(0, 32'd1, w);
        repeat (4) @(negedge clk);
        bus_read(4, rd, w2);
        check("busy_status", rd, 32'h1);
        check("busy_status_nostall", w2, 32'd0);
        @(negedge clk);
        bus.slave_address   = 4'd1;
        bus.slave_writedata = 32'h5000;
        bus.slave_write     = 1'b1;
        #1;
        check("busy_dest_wr_stalls", {31'd0, bus.slave_waitrequest}, 32'd1);
        hold_ok = 1'b1;
        n = 0;
        while (bus.slave_waitrequest === 1'b1 && n < 200) begin
          if (bus.dest_addr !== 32'h1000) hold_ok = 1'b0;
          @(negedge clk); #1; n++;
        end
        if (bus.slave_waitrequest !== 1'b0) bound_fail("busy_dest_stall");
        check("busy_dest_held", {31'd0, hold_ok}, 32'd1);
        check("busy_dest_pre_accept", bus.dest_addr, 32'h1000);
        @(posedge clk); #1;
        bus.slave_write = 1'b0;
        check("busy_dest_post_accept", bus.dest_addr, 32'h5000);
      end
    join
    read_check("busy_count", 6, 32'd2);
    read_check("busy_cycles", 5, 32'd23);

    // Start timeout: copying never rises
    bus.copying = 1'b0;
    base = en_total;
    bus_write(0, 32'd1, w);
    repeat (30) @(negedge clk);
    #1;
    check("tmo_enable_cycles", en_total - base, 32'd16);
    check("tmo_enable_low", {31'd0, bus.enable}, 32'd0);
    read_check("tmo_status", 4, 32'h8);
    read_check("tmo_count", 6, 32'd2);
    read_check("tmo_cycles", 5, 32'd23);
    bus_read(0, rd, w2);
    check("tmo_ctrl_nostall", w2, 32'd0);

    // Reset in the middle of a copy, with a CTRL read stalled
    bus_write(0, 32'd1, w);
    @(negedge clk);
    bus.copying = 1'b1;
    repeat (3) @(negedge clk);
    bus.slave_address = 4'd0;
    bus.slave_read    = 1'b1;
    #1;
    check("rstm_ctrl_stalled", {31'd0, bus.slave_waitrequest}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rstm_enable", {31'd0, bus.enable}, 32'd0);
    check("rstm_waitrequest", {31'd0, bus.slave_waitrequest}, 32'd0);
    check("rstm_ctrl_rd", bus.slave_readdata, 32'd0);
    check("rstm_dest_out", bus.dest_addr, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.slave_read = 1'b0;
    // copying stays high into IDLE: it must be ignored
    repeat (3) @(negedge clk);
    #1;
    check("spurious_no_enable", {31'd0, bus.enable}, 32'd0);
    for (int a = 1; a <= 6; a++) read_check($sformatf("rstm_reg%0d", a), 4'(a), 32'd0);
    bus.copying = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
